// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg / alu_arbiter_if
//
// Purpose:
//   alu_arbiter_pkg holds the ALU operation encoding (alu_ops) shared by the
//   arbiter, its internal ALU and everything that issues requests.
//   alu_arbiter_if bundles the request and response channels of alu_arbiter.
//
// Interface signals (NUM_REQ requesters, ID_W = $clog2(NUM_REQ)):
//   ReqValid   [NUM_REQ-1:0]        request i valid               (master -> slave)
//   ReqReady   [NUM_REQ-1:0]        request i accepted this cycle (slave -> master)
//   ReqA       [NUM_REQ-1:0][31:0]  operand A per requester       (master -> slave)
//   ReqB       [NUM_REQ-1:0][31:0]  operand B per requester       (master -> slave)
//   ReqOp      alu_ops [NUM_REQ-1:0] operation per requester      (master -> slave)
//   RespValid  1                    response valid                (slave -> master)
//   RespReady  1                    consumer accepts response     (master -> slave)
//   RespId     [ID_W-1:0]           requester owning the response (slave -> master)
//   RespResult [31:0]               ALU result                    (slave -> master)
//   RespZero   1                    ALU zero flag                 (slave -> master)
//
// Modports: master = requesters + response consumer, slave = alu_arbiter.
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ops;
endpackage

interface alu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                ReqValid;
  logic [NUM_REQ-1:0]                ReqReady;
  logic [NUM_REQ-1:0][31:0]          ReqA;
  logic [NUM_REQ-1:0][31:0]          ReqB;
  alu_arbiter_pkg::alu_ops [NUM_REQ-1:0] ReqOp;
  logic                              RespValid;
  logic                              RespReady;
  logic [ID_W-1:0]                   RespId;
  logic [31:0]                       RespResult;
  logic                              RespZero;

  modport master (
    output ReqValid, ReqA, ReqB, ReqOp, RespReady,
    input  ReqReady, RespValid, RespId, RespResult, RespZero
  );

  modport slave (
    input  ReqValid, ReqA, ReqB, ReqOp, RespReady,
    output ReqReady, RespValid, RespId, RespResult, RespZero
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one 32-bit ALU between NUM_REQ (2..4) requesters. A winner is
//   picked in IDLE, its operands are captured, the ALU evaluates them in EXEC,
//   and the registered result is offered on a valid/ready response channel in
//   RESP together with the winner's index. One operation per 3 cycles at most.
//
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  synchronous active-low reset
//   bus    alu_arbiter_if.slave (request + response channels, see interface)
//
// Configuration:
//   ALU_ARB_RR_EN defined   : round-robin arbitration, pointer P starts the
//                             search and moves to winner+1 on every accept.
//   ALU_ARB_RR_EN undefined : fixed priority, lowest index wins.
// ---------------------------------------------------------------------------

// Combinational ALU: 32-bit wrap-around arithmetic, signed SLT.
module alu (
  input  logic [31:0]              a,
  input  logic [31:0]              b,
  input  alu_arbiter_pkg::alu_ops  op,
  output logic [31:0]              result,
  output logic                     zero
);
  import alu_arbiter_pkg::*;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus
);
  import alu_arbiter_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_reg;
  logic [31:0]      op_a_reg;
  logic [31:0]      op_b_reg;
  alu_ops           op_code_reg;
  logic [ID_W-1:0]  op_id_reg;
  logic             resp_valid_reg;
  logic [ID_W-1:0]  resp_id_reg;
  logic [31:0]      resp_result_reg;
  logic             resp_zero_reg;

  logic [ID_W-1:0]  ptr_eff;
  logic             found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    sum;
  logic [ID_W-1:0]  cand;
  logic             accept;
  logic [31:0]      alu_result;
  logic             alu_zero;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0]  ptr_reg;
  assign ptr_eff = ptr_reg;
`else
  // Fixed priority is the round-robin search with the start index pinned at 0.
  assign ptr_eff = '0;
`endif

  // Search ptr_eff, ptr_eff+1, ... (mod NUM_REQ); first valid requester wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_eff} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!found && bus.ReqValid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // Gated by rst_n so no grant is ever shown while the block is held in reset.
  assign accept = rst_n && (state_reg == S_IDLE) && found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign bus.ReqReady[gi] = accept && (win_id == ID_W'(gi));
  end

  alu u_alu (
    .a      (op_a_reg),
    .b      (op_b_reg),
    .op     (op_code_reg),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      op_code_reg     <= ALU_ADD;
      op_id_reg       <= '0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= '0;
      resp_result_reg <= '0;
      resp_zero_reg   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_a_reg    <= bus.ReqA[win_id];
            op_b_reg    <= bus.ReqB[win_id];
            op_code_reg <= bus.ReqOp[win_id];
            op_id_reg   <= win_id;
`ifdef ALU_ARB_RR_EN
            ptr_reg     <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
`endif
            state_reg   <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_result_reg <= alu_result;
          resp_zero_reg   <= alu_zero;
          resp_id_reg     <= op_id_reg;
          resp_valid_reg  <= 1'b1;
          state_reg       <= S_RESP;
        end
        S_RESP: begin
          // Response registers hold their value until the consumer takes it.
          if (bus.RespReady) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RespValid  = resp_valid_reg;
  assign bus.RespId     = resp_id_reg;
  assign bus.RespResult = resp_result_reg;
  assign bus.RespZero   = resp_zero_reg;
endmodule
